// File: rtl/time_counter_30s_if.sv
// Round timer control/display bundle.
// Carries the start request in and seconds/pause status out.
`timescale 1ns/1ps
interface time_counter_30s_if;
  logic       start;
  logic [4:0] time_display;
  logic       pause;

  modport master (
    output start,
    input  time_display,
    input  pause
  );

  modport slave (
    input  start,
    output time_display,
    output pause
  );
endinterface

// File: rtl/time_counter_30s.sv
// Game round countdown timer: START_TIME..0 seconds.
// Raises pause at expiry; a new start edge reloads and restarts.
`timescale 1ns/1ps
module time_counter_30s #(
  parameter int CLKS_PER_SEC = 100_000_000,
  parameter int START_TIME   = 30
) (
  input  logic              clk,
  input  logic              rst,
  time_counter_30s_if.slave tmr
);

  localparam int PW =
    (CLKS_PER_SEC > 1) ? $clog2(CLKS_PER_SEC) : 1;
  localparam logic [PW-1:0] PS_LAST =
    PW'(CLKS_PER_SEC - 1);
  localparam logic [4:0] T_LOAD =
    5'(START_TIME);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

  state_t        state;
  logic [PW-1:0] prescaler;
  logic [4:0]    time_display;
  logic          pause;
  logic          start_q;
  logic          start_evt;
  logic          tick;

  // start_q keeps following start through reset,
  // so a button held across reset release cannot fire.
  always_ff @(posedge clk) begin
    start_q <= tmr.start;
  end

  assign start_evt = tmr.start & ~start_q;
  assign tick      = (prescaler == PS_LAST);

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      time_display <= T_LOAD;
      pause        <= 1'b0;
      prescaler    <= '0;
    end else if (start_evt) begin
      state        <= RUN;
      time_display <= T_LOAD;
      pause        <= 1'b0;
      prescaler    <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          time_display <= T_LOAD;
          pause        <= 1'b0;
          prescaler    <= '0;
        end
        RUN: begin
          if (tick) begin
            prescaler    <= '0;
            time_display <= time_display - 5'd1;
            if (time_display == 5'd1) begin
              pause <= 1'b1;
              state <= DONE;
            end
          end else begin
            prescaler <= prescaler + PW'(1);
          end
        end
        DONE: begin
          time_display <= 5'd0;
          pause        <= 1'b1;
          prescaler    <= '0;
        end
        default: begin
          state     <= IDLE;
          prescaler <= '0;
        end
      endcase
    end
  end

  assign tmr.time_display = time_display;
  assign tmr.pause        = pause;

endmodule

// File: tb/tb_time_counter_30s.sv
// Bench for time_counter_30s: cycle model plus directed
// literal checkpoints along one long scenario.
`timescale 1ns/1ps
module tb_time_counter_30s;

  localparam int CPS = 1000;
  localparam int ST  = 30;

  logic clk = 1'b0;
  logic rst;

  time_counter_30s_if ifc ();

  time_counter_30s #(
    .CLKS_PER_SEC (CPS),
    .START_TIME   (ST)
  ) dut (
    .clk (clk),
    .rst (rst),
    .tmr (ifc.slave)
  );

  always #5 clk = ~clk;

  int compared = 0;
  int mism     = 0;
  int cyc      = 0;

  // model: cycles elapsed since the last start edge
  bit m_act   = 1'b0;
  int m_n     = 0;
  bit m_prev  = 1'b0;
  bit m_armed = 1'b0;
  bit m_evt;

  always @(posedge clk) begin
    cyc++;
    m_evt  = (ifc.start === 1'b1) && !m_prev;
    m_prev = (ifc.start === 1'b1);
    if (rst === 1'b1) begin
      m_act   = 1'b0;
      m_n     = 0;
      m_armed = 1'b1;
    end else if (m_evt) begin
      m_act = 1'b1;
      m_n   = 0;
    end else if (m_act && m_n < ST * CPS) begin
      m_n++;
    end
  end

  function automatic int exp_disp();
    return m_act ? ST - m_n / CPS : ST;
  endfunction

  function automatic int exp_pause();
    return (m_act && m_n >= ST * CPS) ? 1 : 0;
  endfunction

  task automatic check(
    input string       name,
    input logic [31:0] got,
    input logic [31:0] exp
  );
    compared++;
    if (got !== exp) begin
      mism++;
      $display("FAIL %s: got %0d expected %0d at cycle %0d",
               name, got, exp, cyc);
    end
  endtask

  always @(negedge clk) begin
    if (m_armed) begin
      check("model_time", 32'(ifc.time_display), exp_disp());
      check("model_pause", 32'(ifc.pause), exp_pause());
    end
  end

  task automatic lit(
    input string name,
    input int    t,
    input int    p
  );
    check({name, "_time"}, 32'(ifc.time_display), t);
    check({name, "_pause"}, 32'(ifc.pause), p);
    check({name, "_mtime"}, exp_disp(), t);
    check({name, "_mpause"}, exp_pause(), p);
  endtask

  task automatic run_to(input int t);
    while (cyc < t) @(negedge clk);
  endtask

  task automatic pulse(input int hold, output int e);
    e = cyc + 1;
    ifc.start = 1'b1;
    repeat (hold) @(negedge clk);
    ifc.start = 1'b0;
  endtask

  int e, r, r2, r3, t0;

  initial begin
    ifc.start = 1'b0;
    rst = 1'b1;
    repeat (2) @(negedge clk);
    lit("reset", 30, 0);
    rst = 1'b0;
    t0 = cyc;
    run_to(t0 + 5000);
    lit("idle_hold", 30, 0);

    pulse(3, e);
    run_to(e + 999);
    lit("first_pre", 30, 0);
    run_to(e + 1000);
    lit("first_tick", 29, 0);
    run_to(e + 2000);
    lit("second_tick", 28, 0);
    run_to(e + 29000);
    lit("at_one", 1, 0);
    run_to(e + 29999);
    lit("before_zero", 1, 0);
    run_to(e + 30000);
    lit("expire", 0, 1);
    run_to(e + 32500);
    lit("expire_hold", 0, 1);

    pulse(1, r);
    lit("restart_done", 30, 0);
    run_to(r + 999);
    lit("restart_pre", 30, 0);
    run_to(r + 1000);
    lit("restart_tick", 29, 0);
    run_to(r + 13000);
    lit("at_17", 17, 0);

    run_to(r + 13400);
    pulse(1, r2);
    lit("midrun_reload", 30, 0);
    run_to(r2 + 999);
    lit("midrun_pre", 30, 0);
    run_to(r2 + 1000);
    lit("midrun_tick", 29, 0);
    run_to(r2 + 18000);
    lit("at_12", 12, 0);

    run_to(r2 + 18300);
    rst = 1'b1;
    ifc.start = 1'b1;
    @(negedge clk);
    lit("reset_midrun", 30, 0);
    @(negedge clk);
    rst = 1'b0;
    t0 = cyc;
    run_to(t0 + 2000);
    lit("held_no_trigger", 30, 0);
    ifc.start = 1'b0;
    @(negedge clk);

    pulse(1, r3);
    run_to(r3 + 999);
    lit("coinc_pre", 30, 0);
    ifc.start = 1'b1;
    @(negedge clk);
    ifc.start = 1'b0;
    lit("restart_over_tick", 30, 0);
    run_to(r3 + 1999);
    lit("coinc_next_pre", 30, 0);
    run_to(r3 + 2000);
    lit("coinc_next_tick", 29, 0);

    @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             compared, mism);
    $finish;
  end

endmodule
